// File: rtl/fme_arbiter.sv
// Round-robin arbiter sharing one FastModExp engine between the encrypt and
// decrypt input paths; latches operands, issues start, and routes the result back.
module fme_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_req,
  input  logic [WIDTH-1:0] enc_data,
  input  logic             dec_req,
  input  logic [WIDTH-1:0] dec_data,
  input  logic [WIDTH-1:0] e_key,
  input  logic [WIDTH-1:0] d_key,
  input  logic [WIDTH-1:0] n_key,
  input  logic             fme_done,
  input  logic [WIDTH-1:0] fme_result,
  output logic             fme_start,
  output logic [WIDTH-1:0] fme_base,
  output logic [WIDTH-1:0] fme_exp,
  output logic [WIDTH-1:0] fme_mod,
  output logic             enc_ack,
  output logic             dec_ack,
  output logic             enc_valid,
  output logic             dec_valid,
  output logic             enc_err,
  output logic             dec_err,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic OWN_ENC = 1'b0;
  localparam logic OWN_DEC = 1'b1;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic          owner_r;
  logic          last_r;

  logic          grant_s;
  logic          grant_dec_s;
  logic          done_hit_s;
  logic          tmo_hit_s;

  // Next-state and event decode; decrypt wins a tie only when enc was granted last.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    grant_dec_s = 1'b0;
    done_hit_s  = 1'b0;
    tmo_hit_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enc_req || dec_req) begin
          grant_s     = 1'b1;
          grant_dec_s = dec_req && (!enc_req || (last_r == OWN_ENC));
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (fme_done) begin
          done_hit_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          tmo_hit_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, owner bookkeeping and saturating timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      owner_r <= OWN_ENC;
      last_r  <= OWN_ENC;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        owner_r <= grant_dec_s;
        last_r  <= grant_dec_s;
      end
      if (state_r == ST_ISSUE) begin
        cnt_r <= {CW{1'b0}};
      end else if ((state_r == ST_WAIT) && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Operand latches: keys are sampled only at grant and held for the whole job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fme_base <= {WIDTH{1'b0}};
      fme_exp  <= {WIDTH{1'b0}};
      fme_mod  <= {WIDTH{1'b0}};
    end else if (grant_s) begin
      fme_base <= grant_dec_s ? dec_data : enc_data;
      fme_exp  <= grant_dec_s ? d_key : e_key;
      fme_mod  <= n_key;
    end
  end

  // Registered pulses, busy flag and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fme_start <= 1'b0;
      enc_ack   <= 1'b0;
      dec_ack   <= 1'b0;
      enc_valid <= 1'b0;
      dec_valid <= 1'b0;
      enc_err   <= 1'b0;
      dec_err   <= 1'b0;
      busy      <= 1'b0;
      result    <= {WIDTH{1'b0}};
    end else begin
      fme_start <= grant_s;
      enc_ack   <= grant_s && !grant_dec_s;
      dec_ack   <= grant_s && grant_dec_s;
      enc_valid <= done_hit_s && (owner_r == OWN_ENC);
      dec_valid <= done_hit_s && (owner_r == OWN_DEC);
      enc_err   <= tmo_hit_s && (owner_r == OWN_ENC);
      dec_err   <= tmo_hit_s && (owner_r == OWN_DEC);
      if (grant_s) begin
        busy <= 1'b1;
      end else if (done_hit_s || tmo_hit_s) begin
        busy <= 1'b0;
      end
      if (done_hit_s) begin
        result <= fme_result;
      end
    end
  end

endmodule

// File: tb/tb_fme_arbiter.sv
// Directed bench for fme_arbiter (TIMEOUT=8): single job, round-robin, timeout,
// done at the timeout boundary, key change mid-job and asynchronous reset mid-WAIT.
module tb_fme_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enc_req = 1'b0;
  logic [31:0] enc_data = 32'h0;
  logic        dec_req = 1'b0;
  logic [31:0] dec_data = 32'h0;
  logic [31:0] e_key = 32'h0;
  logic [31:0] d_key = 32'h0;
  logic [31:0] n_key = 32'h0;
  logic        fme_done = 1'b0;
  logic [31:0] fme_result = 32'h0;
  logic        fme_start;
  logic [31:0] fme_base, fme_exp, fme_mod, result;
  logic        enc_ack, dec_ack, enc_valid, dec_valid, enc_err, dec_err, busy;
  logic [7:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  fme_arbiter #(.WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .enc_req(enc_req), .enc_data(enc_data),
    .dec_req(dec_req), .dec_data(dec_data),
    .e_key(e_key), .d_key(d_key), .n_key(n_key),
    .fme_done(fme_done), .fme_result(fme_result),
    .fme_start(fme_start), .fme_base(fme_base), .fme_exp(fme_exp), .fme_mod(fme_mod),
    .enc_ack(enc_ack), .dec_ack(dec_ack),
    .enc_valid(enc_valid), .dec_valid(dec_valid),
    .enc_err(enc_err), .dec_err(dec_err),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // {start, busy, enc_ack, dec_ack, enc_valid, dec_valid, enc_err, dec_err}
  assign flags = {fme_start, busy, enc_ack, dec_ack, enc_valid, dec_valid, enc_err, dec_err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!fme_start && n < 40);
    chk("start_seen", {31'b0, fme_start}, 32'd1);
  endtask

  // Pulse fme_done so that valid is sampled rem cycles from the current negedge.
  task automatic done_after(input int rem, input logic [31:0] val);
    repeat (rem - 1) tick();
    fme_done   = 1'b1;
    fme_result = val;
    tick();
    fme_done   = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] acc;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_flags", {24'b0, flags}, 32'h0);
    chk("rst_base", fme_base, 32'h0);
    chk("rst_exp", fme_exp, 32'h0);
    chk("rst_mod", fme_mod, 32'h0);
    chk("rst_result", result, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single decrypt request
    e_key = 32'h3; d_key = 32'h11; n_key = 32'hC5;
    dec_data = 32'h0000_1234; dec_req = 1'b1;
    wait_start(lat);
    chk("t1_lat", lat, 32'd1);
    chk("t1_flags_issue", {24'b0, flags}, 32'b1101_0000);
    chk("t1_base", fme_base, 32'h1234);
    chk("t1_exp", fme_exp, 32'h11);
    chk("t1_mod", fme_mod, 32'hC5);
    dec_req = 1'b0;
    tick();
    chk("t1_flags_wait", {24'b0, flags}, 32'b0100_0000);
    done_after(4, 32'hAB);
    chk("t1_flags_valid", {24'b0, flags}, 32'b0000_0100);
    chk("t1_result", result, 32'hAB);
    tick();
    chk("t1_flags_after", {24'b0, flags}, 32'h0);

    // Tie and round-robin from a fresh reset: dec, enc, dec
    do_reset();
    enc_data = 32'hE0; dec_data = 32'hD0;
    enc_req = 1'b1; dec_req = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_start(lat);
      chk("rr_lat", lat, 32'd1);
      chk("rr_flags_issue", {24'b0, flags}, (j != 1) ? 32'b1101_0000 : 32'b1110_0000);
      chk("rr_exp", fme_exp, (j != 1) ? 32'h11 : 32'h3);
      chk("rr_base", fme_base, (j != 1) ? 32'hD0 : 32'hE0);
      done_after(2, 32'h50 + j);
      if (j == 2) begin
        enc_req = 1'b0;
        dec_req = 1'b0;
      end
      chk("rr_flags_valid", {24'b0, flags}, (j != 1) ? 32'b0000_0100 : 32'b0000_1000);
      chk("rr_result", result, 32'h50 + j);
    end

    // Timeout: err 9 cycles after start, late done ignored
    dec_data = 32'h77; dec_req = 1'b1;
    wait_start(lat);
    dec_req = 1'b0;
    repeat (8) tick();
    chk("to_flags_pre", {24'b0, flags}, 32'b0100_0000);
    tick();
    chk("to_flags_err", {24'b0, flags}, 32'b0000_0001);
    chk("to_result_hold", result, 32'h52);
    fme_done = 1'b1; fme_result = 32'h99;
    tick();
    fme_done = 1'b0;
    chk("to_late_flags", {24'b0, flags}, 32'h0);
    chk("to_late_result", result, 32'h52);
    enc_data = 32'h21; enc_req = 1'b1;
    wait_start(lat);
    chk("to_next_flags", {24'b0, flags}, 32'b1110_0000);
    chk("to_next_base", fme_base, 32'h21);
    enc_req = 1'b0;
    done_after(3, 32'h3C);
    chk("to_next_valid", {24'b0, flags}, 32'b0000_1000);
    chk("to_next_result", result, 32'h3C);

    // Done in the same cycle the counter reaches TIMEOUT-1
    dec_data = 32'h88; dec_req = 1'b1;
    wait_start(lat);
    dec_req = 1'b0;
    done_after(9, 32'h44);
    chk("bd_flags", {24'b0, flags}, 32'b0000_0100);
    chk("bd_result", result, 32'h44);
    tick();
    chk("bd_flags_after", {24'b0, flags}, 32'h0);

    // e_key changes while an enc job is waiting
    enc_data = 32'h66; enc_req = 1'b1;
    wait_start(lat);
    enc_req = 1'b0;
    chk("kc_exp_issue", fme_exp, 32'h3);
    tick();
    tick();
    e_key = 32'h7;
    tick();
    chk("kc_exp_wait", fme_exp, 32'h3);
    done_after(2, 32'h12);
    chk("kc_valid", {24'b0, flags}, 32'b0000_1000);
    chk("kc_exp_end", fme_exp, 32'h3);

    // Asynchronous reset in WAIT
    enc_req = 1'b1; dec_req = 1'b1;
    wait_start(lat);
    tick();
    chk("ar_busy", {24'b0, flags}, 32'b0100_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_flags", {24'b0, flags}, 32'h0);
    chk("ar_base", fme_base, 32'h0);
    chk("ar_exp", fme_exp, 32'h0);
    chk("ar_result", result, 32'h0);
    enc_req = 1'b0; dec_req = 1'b0;
    tick();
    rst_n = 1'b1;
    acc = 8'h0;
    for (int i = 0; i < 12; i++) begin
      fme_done = (i == 3);
      tick();
      acc = acc | flags;
    end
    fme_done = 1'b0;
    chk("ar_quiet", {24'b0, acc}, 32'h0);
    enc_req = 1'b1; dec_req = 1'b1;
    wait_start(lat);
    chk("ar_tie_dec", {24'b0, flags}, 32'b1101_0000);
    enc_req = 1'b0; dec_req = 1'b0;
    done_after(3, 32'h5A);
    chk("ar_valid", {24'b0, flags}, 32'b0000_0100);
    chk("ar_result_new", result, 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
